cache_burst_controller: RTL

CACHE_BURST_CONTROLLER -- requirements
Module: cache_burst_controller

---
 rtl/cache_burst_controller.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cache_burst_controller.sv
// Burst controller for a set-associative cache: handles the hit/miss decision,
// dirty-line write-back, line refill and optional write-through stores.
`ifndef CACHE_T
`define CACHE_T 20
`endif
`ifndef CACHE_S
`define CACHE_S 8
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_burst_controller #(
    parameter int TAG_WIDTH     = `CACHE_T,
    parameter int SET_WIDTH     = `CACHE_S,
    parameter int OFFSET_WIDTH  = `CACHE_B,
    parameter int WRITE_THROUGH = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    write_en_i,
    input  logic [31:0]             addr_i,
    input  logic                    hit_i,
    input  logic                    dirty_i,
    input  logic [TAG_WIDTH-1:0]    tag_line_i,
    input  logic                    mem_ready_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic                    line_write_en_o,
    output logic                    line_update_en_o,
    output logic                    set_valid_o,
    output logic                    set_dirty_o,
    output logic [OFFSET_WIDTH-3:0] offset_line_o,
    output logic                    stall_o,
    output logic [1:0]              state_o
);
    localparam int BEAT_W = OFFSET_WIDTH - 2;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WRITE_BACK = 2'd1,
        S_REFILL     = 2'd2,
        S_WT_WRITE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [BEAT_W-1:0]   r_beat;

    logic [TAG_WIDTH-1:0] w_tag;
    logic [SET_WIDTH-1:0] w_index;
    logic [BEAT_W-1:0]    w_word;
    logic                 w_last;
    logic                 w_burst;
    logic                 w_unused_addr_bits;

    logic                 w_mem_req, w_mem_we, w_line_we, w_line_upd;
    logic                 w_set_valid, w_set_dirty, w_stall;
    logic [31:0]          w_mem_addr;
    logic [BEAT_W-1:0]    w_offset;

    assign w_tag   = addr_i[31 -: TAG_WIDTH];
    assign w_index = addr_i[31-TAG_WIDTH -: SET_WIDTH];
    assign w_word  = addr_i[OFFSET_WIDTH-1:2];
    assign w_last  = (r_beat == {BEAT_W{1'b1}});
    assign w_burst = (r_state == S_WRITE_BACK) || (r_state == S_REFILL);
    assign w_unused_addr_bits = &{1'b0, addr_i[1:0]};

    // Beat counter only tracks line bursts; the single-word write-through
    // store must leave it at 0 for the next burst.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_burst && mem_ready_i) begin
                r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_line_we    = 1'b0;
        w_line_upd   = 1'b0;
        w_set_valid  = 1'b0;
        w_set_dirty  = 1'b0;
        w_stall      = 1'b0;
        w_offset     = '0;
        case (r_state)
            S_IDLE: begin
                if (en_i) begin
                    w_offset = w_word;
                    if (!hit_i) begin
                        w_stall      = 1'b1;
                        w_state_next = (dirty_i && WRITE_THROUGH == 0) ? S_WRITE_BACK : S_REFILL;
                    end else if (write_en_i) begin
                        if (WRITE_THROUGH != 0) begin
                            w_stall      = 1'b1;
                            w_state_next = S_WT_WRITE;
                        end else begin
                            w_line_we   = 1'b1;
                            w_set_valid = 1'b1;
                            w_set_dirty = 1'b1;
                        end
                    end
                end
            end
            S_WRITE_BACK: begin
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = {tag_line_i, w_index, r_beat, 2'b00};
                w_stall    = 1'b1;
                w_offset   = r_beat;
                if (mem_ready_i && w_last) begin
                    w_state_next = S_REFILL;
                end
            end
            S_REFILL: begin
                w_mem_req  = 1'b1;
                w_mem_addr = {w_tag, w_index, r_beat, 2'b00};
                w_stall    = 1'b1;
                w_line_upd = mem_ready_i;
                w_offset   = r_beat;
                if (mem_ready_i && w_last) begin
                    w_set_valid  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WT_WRITE: begin
                w_mem_req  = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = {addr_i[31:2], 2'b00};
                w_stall    = ~mem_ready_i;
                w_offset   = w_word;
                if (mem_ready_i) begin
                    w_line_we    = 1'b1;
                    w_set_valid  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are gated by reset so they drop immediately, even while en_i is high.
    assign mem_req_o        = w_mem_req   & ~rst_i;
    assign mem_we_o         = w_mem_we    & ~rst_i;
    assign mem_addr_o       = rst_i ? '0 : w_mem_addr;
    assign line_write_en_o  = w_line_we   & ~rst_i;
    assign line_update_en_o = w_line_upd  & ~rst_i;
    assign set_valid_o      = w_set_valid & ~rst_i;
    assign set_dirty_o      = w_set_dirty & ~rst_i;
    assign offset_line_o    = rst_i ? '0 : w_offset;
    assign stall_o          = w_stall     & ~rst_i;
    assign state_o          = r_state;
endmodule
